rca: RTL and testbench

Parameterised ripple-carry adder: a chain of one-bit full adders producing an unsigned sum and carry-out combinationally. A registered copy of the result is provided for pipelined consumers. It is the basic adder primitive for datapath blocks that need an explicit carry-in and carry-out and a simple, predictable ripple structure.

---
 rtl/rca_if.sv | 42 ++++
 rtl/rca.sv | 64 ++++++
 tb/tb_rca.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_if.sv
// rca_if: operand/result bundle for the ripple-carry adder.
//   A, B, Cin        operands and carry-in, driven by the master
//   Sum, Cout, Ovf   combinational result, driven by the adder
//   Sum_r, Cout_r, Ovf_r  registered copy of the result, driven by the adder
// The master modport is the consumer side; the slave modport is the adder.
interface rca_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;
    logic [WIDTH-1:0] Sum_r;
    logic             Cout_r;
    logic             Ovf_r;

    modport master (
        output A,
        output B,
        output Cin,
        input  Sum,
        input  Cout,
        input  Ovf,
        input  Sum_r,
        input  Cout_r,
        input  Ovf_r
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        output Sum,
        output Cout,
        output Ovf,
        output Sum_r,
        output Cout_r,
        output Ovf_r
    );
endinterface

// File: rtl/rca.sv
// rca: parameterised ripple-carry adder with a registered result copy.
//   clk   rising-edge clock for the result register
//   rst   synchronous active-high reset of the result register only
//   bus   rca_if slave: A, B, Cin in; Sum, Cout, Ovf combinational out;
//         Sum_r, Cout_r, Ovf_r the same values one clock later
// Sum/Cout/Ovf are independent of clk and rst and valid every cycle.
module rca #(
    parameter int unsigned WIDTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    rca_if.slave  bus
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // Full-adder chain; the carry is propagated through a local variable so
    // the carry vector is only ever written, keeping the ripple a clean chain.
    always_comb begin : fa_chain
        logic v_carry;
        w_c     = '0;
        w_sum   = '0;
        v_carry = bus.Cin;
        w_c[0]  = v_carry;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_sum[i] = bus.A[i] ^ bus.B[i] ^ v_carry;
            v_carry  = (bus.A[i] & bus.B[i]) | (v_carry & (bus.A[i] ^ bus.B[i]));
            w_c[i+1] = v_carry;
        end
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign w_cout = w_c[WIDTH];
    assign w_ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];

    assign bus.Sum  = w_sum;
    assign bus.Cout = w_cout;
    assign bus.Ovf  = w_ovf;

    // Result register; reset takes priority over the incoming result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
        end
    end

    assign bus.Sum_r  = r_sum;
    assign bus.Cout_r = r_cout;
    assign bus.Ovf_r  = r_ovf;

endmodule

// File: tb/tb_rca.sv
// tb_rca: self-checking bench for rca at WIDTH=4 and WIDTH=8.
module tb_rca;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rca_if #(.WIDTH(4)) bus4 ();
    rca_if #(.WIDTH(8)) bus8 ();

    rca #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    rca #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: true integer sum of unsigned operands.
    function automatic int ref_full(int a, int b, int cin);
        return a + b + cin;
    endfunction

    // Reference: overflow of the signed sum of two w-bit two's-complement
    // operands plus a carry-in of 0/1.
    function automatic bit ref_ovf(int w, int a, int b, int cin);
        int sa, sb, s, lim;
        lim = 1 << (w - 1);
        sa  = (a >= lim) ? a - (1 << w) : a;
        sb  = (b >= lim) ? b - (1 << w) : b;
        s   = sa + sb + cin;
        return (s > lim - 1) || (s < -lim);
    endfunction

    task automatic drive4(int a, int b, int cin);
        bus4.A   = 4'(a);
        bus4.B   = 4'(b);
        bus4.Cin = 1'(cin);
    endtask

    task automatic drive8(int a, int b, int cin);
        bus8.A   = 8'(a);
        bus8.B   = 8'(b);
        bus8.Cin = 1'(cin);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive4(3, 4, 0);
        drive8(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus4.Sum_r, bus4.Cout_r, bus4.Ovf_r} !== 6'd0) begin
            bad++;
            $display("FAIL reset_regs4 got=%b exp=0", {bus4.Sum_r, bus4.Cout_r, bus4.Ovf_r});
        end
        total++;
        if ({bus8.Sum_r, bus8.Cout_r, bus8.Ovf_r} !== 10'd0) begin
            bad++;
            $display("FAIL reset_regs8 got=%b exp=0", {bus8.Sum_r, bus8.Cout_r, bus8.Ovf_r});
        end
        total++;
        if ({bus4.Cout, bus4.Sum} !== 5'd7) begin
            bad++;
            $display("FAIL comb_during_reset got=%0d exp=7", {bus4.Cout, bus4.Sum});
        end
    endtask

    task automatic test_exhaustive();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive4(a, b, c);
                    #1;
                    total++;
                    if ({bus4.Cout, bus4.Sum} !== 5'(ref_full(a, b, c))) begin
                        bad++;
                        $display("FAIL exh_sum a=%0d b=%0d c=%0d got=%b exp=%0d",
                                 a, b, c, {bus4.Cout, bus4.Sum}, ref_full(a, b, c));
                    end
                    total++;
                    if (bus4.Ovf !== ref_ovf(4, a, b, c)) begin
                        bad++;
                        $display("FAIL exh_ovf a=%0d b=%0d c=%0d got=%b exp=%b",
                                 a, b, c, bus4.Ovf, ref_ovf(4, a, b, c));
                    end
                end
            end
        end
    endtask

    task automatic test_ripple();
        drive4(15, 0, 1);
        #1;
        total++;
        if ({bus4.Cout, bus4.Sum} !== 5'b1_0000) begin
            bad++;
            $display("FAIL ripple_f_0_1 got=%b exp=10000", {bus4.Cout, bus4.Sum});
        end
        drive4(15, 15, 1);
        #1;
        total++;
        if ({bus4.Cout, bus4.Sum} !== 5'b1_1111) begin
            bad++;
            $display("FAIL ripple_f_f_1 got=%b exp=11111", {bus4.Cout, bus4.Sum});
        end
    endtask

    task automatic test_overflow();
        drive4(7, 1, 0);
        #1;
        total++;
        if ({bus4.Cout, bus4.Sum, bus4.Ovf} !== 6'b0_1000_1) begin
            bad++;
            $display("FAIL ovf_pos got=%b exp=010001", {bus4.Cout, bus4.Sum, bus4.Ovf});
        end
        drive4(8, 8, 0);
        #1;
        total++;
        if ({bus4.Cout, bus4.Sum, bus4.Ovf} !== 6'b1_0000_1) begin
            bad++;
            $display("FAIL ovf_neg got=%b exp=100001", {bus4.Cout, bus4.Sum, bus4.Ovf});
        end
        drive4(3, 2, 0);
        #1;
        total++;
        if (bus4.Ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_none got=%b exp=0", bus4.Ovf);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus4.Sum_r, bus4.Cout_r, bus4.Ovf_r} !== 6'd0) begin
            bad++;
            $display("FAIL lat_reset got=%b exp=0", {bus4.Sum_r, bus4.Cout_r, bus4.Ovf_r});
        end
        @(negedge clk);
        rst = 1'b0;
        drive4(9, 8, 1);
        @(posedge clk);
        #1;
        total++;
        if ({bus4.Sum_r, bus4.Cout_r, bus4.Ovf_r} !== 6'b0010_1_1) begin
            bad++;
            $display("FAIL lat_first got=%b exp=001011", {bus4.Sum_r, bus4.Cout_r, bus4.Ovf_r});
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        rst = 1'b0;
        drive4(5, 6, 0);
        @(posedge clk);
        #1;
        total++;
        if (bus4.Sum_r !== 4'd11) begin
            bad++;
            $display("FAIL mid_pre got=%0d exp=11", bus4.Sum_r);
        end
        // Reset and an input change land on the same edge.
        @(negedge clk);
        rst = 1'b1;
        drive4(1, 2, 0);
        @(posedge clk);
        #1;
        total++;
        if ({bus4.Sum_r, bus4.Cout_r, bus4.Ovf_r} !== 6'd0) begin
            bad++;
            $display("FAIL mid_clear got=%b exp=0", {bus4.Sum_r, bus4.Cout_r, bus4.Ovf_r});
        end
        total++;
        if ({bus4.Cout, bus4.Sum} !== 5'd3) begin
            bad++;
            $display("FAIL mid_comb got=%0d exp=3", {bus4.Cout, bus4.Sum});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({bus4.Sum_r, bus4.Cout_r} !== 5'b0011_0) begin
            bad++;
            $display("FAIL mid_resume got=%b exp=00110", {bus4.Sum_r, bus4.Cout_r});
        end
    endtask

    task automatic test_width8();
        drive8(255, 1, 0);
        #1;
        total++;
        if ({bus8.Cout, bus8.Sum} !== 9'h100) begin
            bad++;
            $display("FAIL w8_wrap got=%h exp=100", {bus8.Cout, bus8.Sum});
        end
        for (int n = 0; n < 1000; n++) begin
            int a, b, c;
            a = int'($urandom_range(255));
            b = int'($urandom_range(255));
            c = int'($urandom_range(1));
            drive8(a, b, c);
            #1;
            total++;
            if ({bus8.Cout, bus8.Sum} !== 9'(ref_full(a, b, c)) ||
                bus8.Ovf !== ref_ovf(8, a, b, c)) begin
                bad++;
                $display("FAIL w8_rand a=%0d b=%0d c=%0d got=%0d/%b exp=%0d/%b",
                         a, b, c, {bus8.Cout, bus8.Sum}, bus8.Ovf,
                         ref_full(a, b, c), ref_ovf(8, a, b, c));
            end
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b0;
        for (int n = 0; n < 60; n++) begin
            int a4, b4, c4, a8, b8, c8;
            @(negedge clk);
            a4 = int'($urandom_range(15));
            b4 = int'($urandom_range(15));
            c4 = int'($urandom_range(1));
            a8 = int'($urandom_range(255));
            b8 = int'($urandom_range(255));
            c8 = int'($urandom_range(1));
            drive4(a4, b4, c4);
            drive8(a8, b8, c8);
            @(posedge clk);
            #1;
            total++;
            if ({bus4.Cout_r, bus4.Sum_r} !== 5'(ref_full(a4, b4, c4)) ||
                bus4.Ovf_r !== ref_ovf(4, a4, b4, c4)) begin
                bad++;
                $display("FAIL b2b_reg4 a=%0d b=%0d c=%0d got=%0d/%b exp=%0d/%b",
                         a4, b4, c4, {bus4.Cout_r, bus4.Sum_r}, bus4.Ovf_r,
                         ref_full(a4, b4, c4), ref_ovf(4, a4, b4, c4));
            end
            total++;
            if ({bus8.Cout_r, bus8.Sum_r} !== 9'(ref_full(a8, b8, c8)) ||
                bus8.Ovf_r !== ref_ovf(8, a8, b8, c8)) begin
                bad++;
                $display("FAIL b2b_reg8 a=%0d b=%0d c=%0d got=%0d/%b exp=%0d/%b",
                         a8, b8, c8, {bus8.Cout_r, bus8.Sum_r}, bus8.Ovf_r,
                         ref_full(a8, b8, c8), ref_ovf(8, a8, b8, c8));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive4(0, 0, 0);
        drive8(0, 0, 0);
        test_reset();
        test_exhaustive();
        test_ripple();
        test_overflow();
        test_latency();
        test_reset_midstream();
        test_width8();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
